alu_sched: RTL and testbench

//  Round-robin scheduler sharing one clocked ALU (1-cycle result latency) among NREQ requesters.

---
 rtl/alu_sched.sv | 153 +++++++++++++++
 tb/tb_alu_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one 1-cycle-latency ALU among NREQ requesters,
// returning tagged results in issue order. Define ALU_SCHED_PERF_EN for perf_issue/perf_stall counters.
module alu_sched #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned OP_W      = 3,
   parameter int unsigned RSP_DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*DATA_W-1:0]   req_a,
   input  logic [NREQ*DATA_W-1:0]   req_b,
   input  logic [NREQ*OP_W-1:0]     req_op,
   output logic [DATA_W-1:0]        alu_a,
   output logic [DATA_W-1:0]        alu_b,
   output logic [OP_W-1:0]          alu_op,
   input  logic [DATA_W-1:0]        alu_out,
   input  logic                     alu_zero,
   input  logic                     alu_negative,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_W-1:0]        rsp_data,
   output logic                     rsp_zero,
   output logic                     rsp_negative,
   output logic [$clog2(NREQ)-1:0]  rsp_id
`ifdef ALU_SCHED_PERF_EN
   ,
   output logic [31:0]              perf_issue,
   output logic [31:0]              perf_stall
`endif
);

   localparam int unsigned ID_W   = $clog2(NREQ);
   localparam int unsigned PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);
   localparam int unsigned FREE_W = CNT_W + 1;

   logic [ID_W-1:0]   rr_ptr;
   logic              inflight;
   logic [ID_W-1:0]   inflight_id;
   logic [CNT_W-1:0]  count;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   logic [DATA_W-1:0] mem_data [RSP_DEPTH];
   logic              mem_zero [RSP_DEPTH];
   logic              mem_neg  [RSP_DEPTH];
   logic [ID_W-1:0]   mem_id   [RSP_DEPTH];

   logic              pop;
   logic              push;
   logic [FREE_W-1:0] free;
   logic              grant_hit;
   logic [ID_W-1:0]   grant_id;
   logic              issue;
   int unsigned       idx;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Credits: slots not yet claimed by stored or in-flight results; a same-cycle pop frees one.
   assign pop   = rsp_valid & rsp_ready;
   assign push  = inflight;
   assign free  = FREE_W'(RSP_DEPTH) + FREE_W'(pop) - FREE_W'(count) - FREE_W'(inflight);
   assign issue = n_rst & grant_hit & (free != '0);

   // Round-robin search starting just above the last granted requester.
   always_comb begin
      grant_hit = 1'b0;
      grant_id  = '0;
      idx       = 0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = (32'(rr_ptr) + k) % NREQ;
         if (!grant_hit && req_valid[ID_W'(idx)]) begin
            grant_hit = 1'b1;
            grant_id  = ID_W'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      alu_a     = '0;
      alu_b     = '0;
      alu_op    = '0;
      if (issue) begin
         req_ready = NREQ'(1) << grant_id;
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_id == ID_W'(i)) begin
               alu_a  = req_a[i*DATA_W +: DATA_W];
               alu_b  = req_b[i*DATA_W +: DATA_W];
               alu_op = req_op[i*OP_W +: OP_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rr_ptr      <= ID_W'(NREQ - 1);
         inflight    <= 1'b0;
         inflight_id <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_id <= grant_id;
            rr_ptr      <= grant_id;
         end
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Result storage; contents are only observable through the count-qualified head.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= alu_out;
         mem_zero[wr_ptr] <= alu_zero;
         mem_neg[wr_ptr]  <= alu_negative;
         mem_id[wr_ptr]   <= inflight_id;
      end
   end

   assign rsp_valid    = (count != '0);
   assign rsp_data     = rsp_valid ? mem_data[rd_ptr] : '0;
   assign rsp_zero     = rsp_valid ? mem_zero[rd_ptr] : 1'b0;
   assign rsp_negative = rsp_valid ? mem_neg[rd_ptr]  : 1'b0;
   assign rsp_id       = rsp_valid ? mem_id[rd_ptr]   : '0;

`ifdef ALU_SCHED_PERF_EN
   logic stall;
   assign stall = (|req_valid) && (free == '0);

   // Saturating event counters.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         perf_issue <= '0;
         perf_stall <= '0;
      end else begin
         if (issue && (perf_issue != '1)) perf_issue <= perf_issue + 32'd1;
         if (stall && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: scoreboard bench for alu_sched with a behavioural 1-cycle ALU.
// Handshakes push hand-computed expectations; a negedge monitor pops and compares responses.
module tb_alu_sched;

   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                          OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_BAD = 3'd7;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [31:0] d;
      logic        z;
      logic        n;
   } vec_t;

   typedef struct packed {
      logic [31:0] d;
      logic        z;
      logic        n;
      logic [1:0]  id;
      logic [31:0] cyc;
   } exp_t;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] cyc;
   } gnt_t;

   logic         clk = 1'b0;
   logic         n_rst = 1'b0;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_a, req_b;
   logic [11:0]  req_op;
   logic [31:0]  alu_a, alu_b, alu_out, alu_res;
   logic [2:0]   alu_op;
   logic         alu_zero, alu_negative;
   logic         rsp_valid, rsp_ready = 1'b1;
   logic [31:0]  rsp_data;
   logic         rsp_zero, rsp_negative;
   logic [1:0]   rsp_id;
`ifdef ALU_SCHED_PERF_EN
   logic [31:0]  perf_issue, perf_stall;
   logic [31:0]  pi0, ps0;
`endif

   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   bit          chk_lat = 1'b1;
   vec_t        tbl [4][16];
   int          hd [4];
   int          tl [4];
   exp_t        sb [$];
   gnt_t        gl [$];

   alu_sched dut (
      .clk(clk), .n_rst(n_rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_out(alu_out), .alu_zero(alu_zero), .alu_negative(alu_negative),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_negative(rsp_negative), .rsp_id(rsp_id)
`ifdef ALU_SCHED_PERF_EN
      , .perf_issue(perf_issue), .perf_stall(perf_stall)
`endif
   );

   initial forever #5 clk = ~clk;

   always_comb begin
      case (alu_op)
         OP_ADD:  alu_res = alu_a + alu_b;
         OP_SUB:  alu_res = alu_a - alu_b;
         OP_AND:  alu_res = alu_a & alu_b;
         OP_OR:   alu_res = alu_a | alu_b;
         OP_XOR:  alu_res = alu_a ^ alu_b;
         OP_SLL:  alu_res = alu_a << alu_b[4:0];
         OP_SRL:  alu_res = alu_a >> alu_b[4:0];
         default: alu_res = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      alu_out      <= alu_res;
      alu_zero     <= (alu_res == 32'd0);
      alu_negative <= alu_res[31];
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic ld(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                     input logic [31:0] d, input logic z, input logic n);
      vec_t v;
      v.a = a; v.b = b; v.op = op; v.d = d; v.z = z; v.n = n;
      tbl[i][tl[i]] = v;
      tl[i]++;
   endtask

   function automatic bit pending();
      bit p = 1'b0;
      for (int i = 0; i < 4; i++) if (hd[i] < tl[i]) p = 1'b1;
      return p;
   endfunction

   task automatic drain(input string nm);
      int k = 0;
      while ((sb.size() != 0 || pending()) && k < 200) begin
         @(posedge clk);
         k++;
      end
      checks++;
      if (k >= 200) begin
         errors++;
         $display("FAIL %s_drain: got %0d outstanding expected 0", nm, sb.size());
      end
   endtask

   task automatic wait_grants(input string nm, input int n);
      int k = 0;
      while (gl.size() < n && k < 100) begin
         @(posedge clk);
         k++;
      end
      chk({nm, "_grants"}, 32'(gl.size()), 32'(n));
   endtask

   // Request driver: present each requester's head vector after every clock edge.
   initial begin
      req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            if (hd[i] < tl[i]) begin
               req_valid[i]       = 1'b1;
               req_a[i*32 +: 32]  = tbl[i][hd[i]].a;
               req_b[i*32 +: 32]  = tbl[i][hd[i]].b;
               req_op[i*3 +: 3]   = tbl[i][hd[i]].op;
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
   end

   // Monitor: compare popped responses, then record accepted requests as expectations.
   initial forever begin
      exp_t e;
      gnt_t g;
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got id %0d data 0x%0h expected none", rsp_id, rsp_data);
         end else begin
            e = sb.pop_front();
            chk("rsp_data", rsp_data, e.d);
            chk("rsp_zero", 32'(rsp_zero), 32'(e.z));
            chk("rsp_negative", 32'(rsp_negative), 32'(e.n));
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            if (chk_lat) chk("rsp_latency", cyc - e.cyc, 32'd2);
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            e.d = tbl[i][hd[i]].d; e.z = tbl[i][hd[i]].z; e.n = tbl[i][hd[i]].n;
            e.id = 2'(i); e.cyc = cyc;
            sb.push_back(e);
            g.id = 2'(i); g.cyc = cyc;
            gl.push_back(g);
            hd[i]++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      chk("reset_alu_a", alu_a, 32'd0);
      chk("reset_alu_op", 32'(alu_op), 32'd0);
      chk("reset_rsp_data", rsp_data, 32'd0);
`ifdef ALU_SCHED_PERF_EN
      chk("reset_perf_issue", perf_issue, 32'd0);
`endif
      @(negedge clk);
      n_rst = 1'b1;

      // All four requesters streaming SUB a=i,b=i; pointer starts at 3 so order is 0,1,2,3,...
      gl.delete();
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < 4; i++) ld(i, 32'(i), 32'(i), OP_SUB, 32'd0, 1'b1, 1'b0);
      drain("rr");
      chk("rr_count", 32'(gl.size()), 32'd12);
      if (gl.size() == 12) begin
         for (int k = 0; k < 12; k++) chk("rr_order", 32'(gl[k].id), 32'(k % 4));
         chk("rr_one_per_cycle", gl[11].cyc - gl[0].cyc, 32'd11);
      end

      // Single requester ADD 5+7.
      gl.delete();
      ld(0, 32'd5, 32'd7, OP_ADD, 32'd12, 1'b0, 1'b0);
      drain("single");
      chk("single_id", (gl.size() > 0) ? 32'(gl[0].id) : 32'hDEAD, 32'd0);

      // Arithmetic boundaries and an invalid opcode on requester 3.
      ld(3, 32'd0,         32'd1,         OP_SUB, 32'hFFFF_FFFF, 1'b0, 1'b1);
      ld(3, 32'd1,         32'd31,        OP_SLL, 32'h8000_0000, 1'b0, 1'b1);
      ld(3, 32'd3,         32'd4,         OP_BAD, 32'd0,         1'b1, 1'b0);
      ld(3, 32'hFFFF_FFFF, 32'd1,         OP_ADD, 32'd0,         1'b1, 1'b0);
      ld(3, 32'h8000_0000, 32'd4,         OP_SRL, 32'h0800_0000, 1'b0, 1'b0);
      ld(3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_AND, 32'h00F0_00F0, 1'b0, 1'b0);
      drain("arith");

      // Backpressure: two issues fill the FIFO, then issue resumes with the first pop.
      @(negedge clk);
      chk_lat = 1'b0;
      rsp_ready = 1'b0;
      gl.delete();
      ld(1, 32'hFF00_FF00, 32'h0F0F_0F0F, OP_XOR, 32'hF00F_F00F, 1'b0, 1'b1);
      ld(1, 32'h1234_5678, 32'h1234_5678, OP_XOR, 32'd0,         1'b1, 1'b0);
      ld(1, 32'h0000_000A, 32'h0000_0005, OP_XOR, 32'h0000_000F, 1'b0, 1'b0);
      ld(1, 32'h8000_0000, 32'd0,         OP_XOR, 32'h8000_0000, 1'b0, 1'b1);
      ld(1, 32'd0,         32'd0,         OP_XOR, 32'd0,         1'b1, 1'b0);
      @(posedge clk);
      #2;
`ifdef ALU_SCHED_PERF_EN
      pi0 = perf_issue;
      ps0 = perf_stall;
`endif
      repeat (10) @(posedge clk);
      #2;
      chk("bp_issues", 32'(gl.size()), 32'd2);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
`ifdef ALU_SCHED_PERF_EN
      chk("perf_issue", perf_issue - pi0, 32'd2);
      chk("perf_stall", perf_stall - ps0, 32'd8);
`endif
      rsp_ready = 1'b1;
      #1;
      chk("bp_resume", 32'(req_ready), 32'b0010);
      drain("bp");

      // Reset with one stored result and one in flight; nothing stale may emerge.
      @(negedge clk);
      chk_lat = 1'b1;
      rsp_ready = 1'b0;
      gl.delete();
      ld(2, 32'd1, 32'd1, OP_ADD, 32'd2, 1'b0, 1'b0);
      ld(2, 32'd2, 32'd2, OP_ADD, 32'd4, 1'b0, 1'b0);
      ld(2, 32'd3, 32'd3, OP_ADD, 32'd6, 1'b0, 1'b0);
      wait_grants("pre_rst", 2);
      #1;
      chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("pre_rst_rsp_data", rsp_data, 32'd2);
      n_rst = 1'b0;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      sb.delete();
      gl.delete();
      for (int i = 0; i < 4; i++) begin
         hd[i] = 0;
         tl[i] = 0;
      end
      repeat (2) @(posedge clk);
      ld(0, 32'd10,   32'd20,   OP_ADD, 32'd30,   1'b0, 1'b0);
      ld(3, 32'h00F0, 32'h000F, OP_OR,  32'h00FF, 1'b0, 1'b0);
      rsp_ready = 1'b1;
      @(posedge clk);
      #3;
      n_rst = 1'b1;
      wait_grants("post_rst", 2);
      if (gl.size() >= 2) begin
         chk("post_rst_first", 32'(gl[0].id), 32'd0);
         chk("post_rst_second", 32'(gl[1].id), 32'd3);
      end
      drain("post_rst");
      repeat (5) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
